// File: rtl/song_sequencer_if.sv
// ROM read port between the song sequencer and its event ROM.
// The sequencer drives the strobe/address; the ROM answers one cycle later.
interface song_sequencer_if #(
    parameter int ADDR_W = 8
);
    logic              rom_rd;
    logic [ADDR_W-1:0] rom_addr;
    logic [15:0]       rom_data;

    modport master (
        output rom_rd,
        output rom_addr,
        input  rom_data
    );

    modport slave (
        input  rom_rd,
        input  rom_addr,
        output rom_data
    );
endinterface

// File: rtl/song_sequencer.sv
// Song playback controller: walks event words from ROM and times
// the one-hot note vector driven to the audio block.
module song_sequencer #(
    parameter int ADDR_W     = 8,
    parameter int TICK_DIV   = 100000,
    parameter int BEAT_TICKS = 125,
    parameter int GAP_TICKS  = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
    input  logic [ADDR_W-1:0] song_base,
    song_sequencer_if.master  rom,
    output logic [8:0]        notes,
    output logic              playing,
    output logic              done
);
    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int TIB_W = (BEAT_TICKS > 1) ? $clog2(BEAT_TICKS) : 1;
    localparam int GAP_W = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [TIB_W-1:0] TIB_LAST = TIB_W'(BEAT_TICKS - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_TICKS - 1);

    typedef enum logic [2:0] {
        IDLE, FETCH, WAIT, LOAD, PLAY, GAP
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d, base_q, base_d, addr_inc;
    logic              wrap_q, wrap_d;
    logic [PRE_W-1:0]  pre_q, pre_d;
    logic [TIB_W-1:0]  tib_q, tib_d;
    logic [7:0]        beats_q, beats_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [8:0]        note_q, note_d, notes_q, notes_d;
    logic              rd_q, rd_d, done_q, done_d, play_q, play_d;
    logic              tick, to_fetch;

    logic [2:0] ev_note;
    logic [1:0] ev_oct;
    logic [7:0] ev_dur;
    logic [8:0] ev_notes;
    logic       unused_bits;

    assign ev_note     = rom.rom_data[12:10];
    assign ev_oct      = rom.rom_data[14:13];
    assign ev_dur      = rom.rom_data[7:0];
    assign unused_bits = ^rom.rom_data[9:8];
    assign ev_notes    = (ev_note == 3'd0) ? 9'd0 :
                         {ev_oct == 2'b10, ev_oct == 2'b01,
                          7'd1 << (ev_note - 3'd1)};

    assign addr_inc = addr_q + 1'b1;
    assign tick     = (pre_q == PRE_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            base_q  <= '0;
            wrap_q  <= 1'b0;
            pre_q   <= '0;
            tib_q   <= '0;
            beats_q <= '0;
            gap_q   <= '0;
            note_q  <= '0;
            notes_q <= '0;
            rd_q    <= 1'b0;
            done_q  <= 1'b0;
            play_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            base_q  <= base_d;
            wrap_q  <= wrap_d;
            pre_q   <= pre_d;
            tib_q   <= tib_d;
            beats_q <= beats_d;
            gap_q   <= gap_d;
            note_q  <= note_d;
            notes_q <= notes_d;
            rd_q    <= rd_d;
            done_q  <= done_d;
            play_q  <= play_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        base_d   = base_q;
        wrap_d   = wrap_q;
        pre_d    = pre_q;
        tib_d    = tib_q;
        beats_d  = beats_q;
        gap_d    = gap_q;
        note_d   = note_q;
        notes_d  = notes_q;
        rd_d     = 1'b0;
        done_d   = 1'b0;
        to_fetch = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    addr_d  = song_base;
                    base_d  = song_base;
                    wrap_d  = 1'b0;
                    rd_d    = 1'b1;
                    state_d = FETCH;
                end
            end
            FETCH: state_d = WAIT;
            WAIT:  state_d = LOAD;
            LOAD: begin
                if (rom.rom_data[15]) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    beats_d = (ev_dur == 8'd0) ? 8'd1 : ev_dur;
                    tib_d   = TIB_LAST;
                    pre_d   = '0;
                    note_d  = ev_notes;
                    notes_d = ev_notes;
                    addr_d  = addr_inc;
                    wrap_d  = (addr_inc == base_q);
                    state_d = PLAY;
                end
            end
            PLAY: begin
                // Paused cycles mute the output but keep the decoded note
                if (pause) begin
                    notes_d = '0;
                end else begin
                    notes_d = note_q;
                    pre_d   = tick ? '0 : pre_q + 1'b1;
                    if (tick) begin
                        if (tib_q != '0) begin
                            tib_d = tib_q - 1'b1;
                        end else if (beats_q != 8'd1) begin
                            tib_d   = TIB_LAST;
                            beats_d = beats_q - 8'd1;
                        end else begin
                            notes_d = '0;
                            gap_d   = '0;
                            if (GAP_TICKS == 0) to_fetch = 1'b1;
                            else state_d = GAP;
                        end
                    end
                end
            end
            GAP: begin
                notes_d = '0;
                if (!pause) begin
                    pre_d = tick ? '0 : pre_q + 1'b1;
                    if (tick) begin
                        if (gap_q == GAP_LAST) to_fetch = 1'b1;
                        else gap_d = gap_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A full ROM pass with no end marker finishes instead of refetching
        if (to_fetch) begin
            if (wrap_q) begin
                done_d  = 1'b1;
                state_d = IDLE;
            end else begin
                rd_d    = 1'b1;
                state_d = FETCH;
            end
        end

        if (stop && state_q != IDLE) begin
            state_d = IDLE;
            rd_d    = 1'b0;
            done_d  = 1'b0;
        end

        if (state_d == IDLE) notes_d = '0;
        play_d = (state_d != IDLE);
    end

    assign rom.rom_rd   = rd_q;
    assign rom.rom_addr = addr_q;
    assign notes        = notes_q;
    assign playing      = play_q;
    assign done         = done_q;
endmodule

// File: tb/tb_song_sequencer.sv
// Scoreboard bench for song_sequencer: expected note segments and done
// pulses are queued by the stimulus and matched by a negedge monitor.
module tb_song_sequencer;
    localparam int AW = 4;

    typedef struct {
        bit         is_done;
        logic [8:0] val;
        int         len;
    } ev_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          pause = 1'b0;
    logic [AW-1:0] song_base = '0;
    logic [8:0]    notes;
    logic          playing;
    logic          done;
    logic [15:0]   mem [16];

    ev_t        exp_q [$];
    int         total = 0;
    int         passed = 0;
    logic [8:0] cur_val = '0;
    int         cur_len = 0;

    song_sequencer_if #(.ADDR_W(AW)) rif ();

    song_sequencer #(
        .ADDR_W(AW), .TICK_DIV(4), .BEAT_TICKS(2), .GAP_TICKS(1)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .pause(pause), .song_base(song_base), .rom(rif),
        .notes(notes), .playing(playing), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (rif.rom_rd) rif.rom_data <= mem[rif.rom_addr];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic push(input bit d, input int v, input int l);
        ev_t e;
        e.is_done = d;
        e.val = 9'(v);
        e.len = l;
        exp_q.push_back(e);
    endtask

    task automatic emit(input bit d, input logic [8:0] v, input int l);
        ev_t e;
        if (exp_q.size() == 0) begin
            check("unexpected_event", 1, 0);
        end else begin
            e = exp_q.pop_front();
            check("ev_kind", int'(d), int'(e.is_done));
            if (!d) begin
                check("seg_value", int'(v), int'(e.val));
                check("seg_len", l, e.len);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (cur_len > 0 && (!playing || notes != cur_val)) begin
                emit(1'b0, cur_val, cur_len);
                cur_len = 0;
            end
            if (playing) begin
                if (cur_len == 0) cur_val = notes;
                cur_len++;
            end
            if (done) emit(1'b1, '0, 0);
        end
    end

    task automatic start_song(input int base);
        @(negedge clk);
        song_base = AW'(base);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain(input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !playing) break;
        end
        check("drain_timeout", exp_q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic push_single();
        push(0, 0, 3);
        push(0, 'h004, 16);
        push(0, 0, 7);
        push(1, 0, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        foreach (mem[i]) mem[i] = 16'h8000;
        mem[0] = 16'h0C02;
        mem[1] = 16'h8000;
        mem[2] = 16'h2401;
        mem[3] = 16'h0001;
        mem[4] = 16'h4400;
        mem[5] = 16'h8000;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_notes", int'(notes), 0);
        check("rst_playing", int'(playing), 0);
        check("rst_done", int'(done), 0);
        check("rst_rom_rd", int'(rif.rom_rd), 0);
        check("rst_rom_addr", int'(rif.rom_addr), 0);

        // single note
        push_single();
        start_song(0);
        drain(200);

        // octave, rest, zero duration
        push(0, 0, 3);
        push(0, 'h081, 8);
        push(0, 0, 22);
        push(0, 'h101, 8);
        push(0, 0, 7);
        push(1, 0, 0);
        start_song(2);
        drain(300);

        // pause for 20 cycles halfway through the note
        push(0, 0, 3);
        push(0, 'h004, 9);
        push(0, 0, 20);
        push(0, 'h004, 7);
        push(0, 0, 7);
        push(1, 0, 0);
        start_song(0);
        repeat (11) @(negedge clk);
        pause = 1'b1;
        repeat (20) @(negedge clk);
        pause = 1'b0;
        drain(300);

        // stop mid-note, then replay from a different base
        push(0, 0, 3);
        push(0, 'h004, 3);
        start_song(0);
        repeat (5) @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("stop_notes", int'(notes), 0);
        check("stop_playing", int'(playing), 0);
        drain(50);
        push(0, 0, 3);
        push(0, 'h081, 8);
        push(0, 0, 22);
        push(0, 'h101, 8);
        push(0, 0, 7);
        push(1, 0, 0);
        start_song(2);
        drain(300);

        // start during playback is ignored
        push_single();
        start_song(0);
        repeat (5) @(negedge clk);
        song_base = AW'(2);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain(200);

        // start and stop together in IDLE
        @(negedge clk);
        song_base = '0;
        start = 1'b1;
        stop = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("collide_playing", int'(playing), 0);
            check("collide_rom_rd", int'(rif.rom_rd), 0);
            @(negedge clk);
        end

        // wrap guard: no end marker anywhere
        foreach (mem[i]) mem[i] = 16'(((i % 7) + 1) << 10) | 16'd1;
        push(0, 0, 3);
        for (int k = 0; k < 16; k++) begin
            int a;
            a = (5 + k) % 16;
            push(0, 1 << (a % 7), 8);
            push(0, 0, (k == 15) ? 4 : 7);
        end
        push(1, 0, 0);
        start_song(5);
        drain(600);
        check("wrap_playing", int'(playing), 0);

        check("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
